// File: rtl/pad_responder.sv
// pad_responder: device end of the pad serial link; returns ID and button bytes, pulses ack_n between bytes.
// Define PAD_RESPONDER_ANALOG_EN to add analog_mode/sticks and the 9-byte analog response.
`timescale 1ns/1ps
module pad_responder #(
    parameter logic [7:0] PAD_ID    = 8'h41,
    parameter int         ACK_DELAY = 8,
    parameter int         ACK_WIDTH = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        sel_n,
    input  logic        sclk,
    input  logic        cmd,
    output logic        dat,
    output logic        ack_n,
    input  logic [15:0] buttons,
`ifdef PAD_RESPONDER_ANALOG_EN
    input  logic        analog_mode,
    input  logic [31:0] sticks,
`endif
    output logic        motor_small,
    output logic [7:0]  motor_large,
    output logic        busy,
    output logic        poll_done
);
    typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK, DONE, IGNORE} state_t;
    state_t      state, state_nx;
    logic [2:0]  sel_s, sclk_s;
    logic [1:0]  cmd_s;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic [3:0]  byte_idx, byte_idx_nx, next_idx, last_idx;
    logic [15:0] tmr, tmr_nx;
    logic [7:0]  tx, tx_nx, rx, rx_nx, rx_byte, next_byte, id_byte, ml_nx;
    logic [15:0] btn_q;
    logic        dat_nx, ack_nx, busy_nx, done_nx, ms_nx, snap;
    logic        sel_fall, sclk_fall, sclk_rise;
`ifdef PAD_RESPONDER_ANALOG_EN
    logic [31:0] stk_q;
    logic        ana_q;
    assign id_byte  = ana_q ? 8'h73 : PAD_ID;
    assign last_idx = ana_q ? 4'd8 : 4'd4;
`else
    assign id_byte  = PAD_ID;
    assign last_idx = 4'd4;
`endif
    // sel_n sync resets low so a select already held at reset release is not seen as a fall
    assign sel_fall  = sel_s[2] & ~sel_s[1];
    assign sclk_fall = sclk_s[2] & ~sclk_s[1];
    assign sclk_rise = ~sclk_s[2] & sclk_s[1];
    assign next_idx  = byte_idx + 4'd1;
    assign rx_byte   = {cmd_s[1], rx[7:1]};
    always_comb begin
        next_byte = 8'hFF;
        case (next_idx)
            4'd1: next_byte = id_byte;
            4'd2: next_byte = 8'h5A;
            4'd3: next_byte = btn_q[7:0];
            4'd4: next_byte = btn_q[15:8];
`ifdef PAD_RESPONDER_ANALOG_EN
            4'd5: next_byte = stk_q[7:0];
            4'd6: next_byte = stk_q[15:8];
            4'd7: next_byte = stk_q[23:16];
            4'd8: next_byte = stk_q[31:24];
`endif
            default: next_byte = 8'hFF;
        endcase
    end
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        byte_idx_nx = byte_idx;
        tmr_nx      = tmr;
        tx_nx       = tx;
        rx_nx       = rx;
        dat_nx      = dat;
        ack_nx      = ack_n;
        busy_nx     = busy;
        done_nx     = 1'b0;
        ms_nx       = motor_small;
        ml_nx       = motor_large;
        snap        = 1'b0;
        if (sel_s[1]) begin
            state_nx    = IDLE;
            dat_nx      = 1'b1;
            ack_nx      = 1'b1;
            busy_nx     = 1'b0;
            bit_cnt_nx  = 3'd0;
            byte_idx_nx = 4'd0;
            tmr_nx      = 16'd0;
        end else begin
            case (state)
                IDLE: if (sel_fall) begin
                    state_nx    = SHIFT;
                    tx_nx       = 8'hFF;
                    busy_nx     = 1'b1;
                    snap        = 1'b1;
                    bit_cnt_nx  = 3'd0;
                    byte_idx_nx = 4'd0;
                end
                SHIFT, ACK_WAIT, ACK: if (sclk_fall) begin
                    // a fall while an ack is pending abandons the ack and starts the next byte
                    state_nx = SHIFT;
                    ack_nx   = 1'b1;
                    dat_nx   = tx[0];
                    tx_nx    = {1'b1, tx[7:1]};
                end else if (state == SHIFT && sclk_rise) begin
                    rx_nx      = rx_byte;
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ms_nx = byte_idx == 4'd3 ? rx_byte[0] : motor_small;
                        ml_nx = byte_idx == 4'd4 ? rx_byte : motor_large;
                        if ((byte_idx == 4'd0 && rx_byte != 8'h01) || (byte_idx == 4'd1 && rx_byte != 8'h42)) begin
                            state_nx = IGNORE;
                            busy_nx  = 1'b0;
                            dat_nx   = 1'b1;
                        end else if (byte_idx == last_idx) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                            dat_nx   = 1'b1;
                        end else begin
                            state_nx    = ACK_WAIT;
                            tmr_nx      = 16'd0;
                            byte_idx_nx = next_idx;
                            tx_nx       = next_byte;
                        end
                    end
                end else if (state == ACK_WAIT) begin
                    state_nx = tmr == 16'(ACK_DELAY - 1) ? ACK : ACK_WAIT;
                    ack_nx   = tmr != 16'(ACK_DELAY - 1);
                    tmr_nx   = tmr == 16'(ACK_DELAY - 1) ? 16'd0 : tmr + 16'd1;
                end else if (state == ACK) begin
                    state_nx = tmr == 16'(ACK_WIDTH - 1) ? SHIFT : ACK;
                    ack_nx   = tmr == 16'(ACK_WIDTH - 1);
                    tmr_nx   = tmr + 16'd1;
                end
                default: begin
                    dat_nx = 1'b1;
                    ack_nx = 1'b1;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            sel_s       <= 3'b000;
            sclk_s      <= 3'b111;
            cmd_s       <= 2'b00;
            bit_cnt     <= 3'd0;
            byte_idx    <= 4'd0;
            tmr         <= 16'd0;
            tx          <= 8'hFF;
            rx          <= 8'h00;
            btn_q       <= 16'hFFFF;
            dat         <= 1'b1;
            ack_n       <= 1'b1;
            busy        <= 1'b0;
            poll_done   <= 1'b0;
            motor_small <= 1'b0;
            motor_large <= 8'h00;
        end else begin
            state       <= state_nx;
            sel_s       <= {sel_s[1:0], sel_n};
            sclk_s      <= {sclk_s[1:0], sclk};
            cmd_s       <= {cmd_s[0], cmd};
            bit_cnt     <= bit_cnt_nx;
            byte_idx    <= byte_idx_nx;
            tmr         <= tmr_nx;
            tx          <= tx_nx;
            rx          <= rx_nx;
            btn_q       <= snap ? buttons : btn_q;
            dat         <= dat_nx;
            ack_n       <= ack_nx;
            busy        <= busy_nx;
            poll_done   <= done_nx;
            motor_small <= ms_nx;
            motor_large <= ml_nx;
        end
    end
`ifdef PAD_RESPONDER_ANALOG_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stk_q <= 32'h8080_8080;
            ana_q <= 1'b0;
        end else if (snap) begin
            stk_q <= sticks;
            ana_q <= analog_mode;
        end
    end
`endif
endmodule

// File: tb/tb_pad_responder.sv
// tb_pad_responder: host-side polls against a byte-level model of the pad response, acks and motor commits.
`timescale 1ns/1ps
module tb_pad_responder;
    localparam int D = 8;
    localparam int W = 4;
    logic        clk = 1'b0, n_reset = 1'b0, sel_n = 1'b0, sclk = 1'b1, cmd = 1'b0;
    logic [15:0] buttons = 16'hFFFF;
    logic        dat, ack_n, motor_small, busy, poll_done;
    logic [7:0]  motor_large;
    int          checks = 0, errors = 0, cyc = 0, last_rise = 0, ack_fall = 0, acks = 0, pdone = 0, tail = 7;
    bit          chk_en = 1'b0, ack_prev = 1'b1;
    logic        ms_m = 1'b0;
    logic [7:0]  ml_m = 8'h00;
    logic [7:0]  got [5];

    pad_responder #(.PAD_ID(8'h41), .ACK_DELAY(D), .ACK_WIDTH(W)) dut (
        .clk(clk), .n_reset(n_reset), .sel_n(sel_n), .sclk(sclk), .cmd(cmd),
        .dat(dat), .ack_n(ack_n), .buttons(buttons), .motor_small(motor_small),
        .motor_large(motor_large), .busy(busy), .poll_done(poll_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] resp(input int b, input logic [15:0] btn);
        logic [7:0] t [5];
        t = '{8'hFF, 8'h41, 8'h5A, btn[7:0], btn[15:8]};
        return t[b];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("idle_motor_small", motor_small, ms_m);
            chk("idle_motor_large", motor_large, ml_m);
            chk("idle_dat", dat, 1);
            chk("idle_ack_n", ack_n, 1);
            chk("idle_busy", busy, 0);
            chk("idle_poll_done", poll_done, 0);
        end
        if (n_reset) begin
            if (!ack_n && ack_prev) begin
                acks++;
                ack_fall = cyc;
                chk("ack_delay", cyc - last_rise, D + 3);
            end
            if (ack_n && !ack_prev) chk("ack_width", cyc - ack_fall, W);
            if (poll_done) pdone++;
        end
        ack_prev = ack_n;
    end

    task automatic send_byte(input logic [7:0] c, input int nbits, output logic [7:0] r);
        r = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 sclk = 1'b0; cmd = c[i];
            repeat (7) @(posedge clk);
            #1 r[i] = dat;
            @(posedge clk); #1 sclk = 1'b1; last_rise = cyc;
            repeat (i == 7 ? tail : 7) @(posedge clk);
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_n && n < 40) begin @(posedge clk); #1 n++; end
        chk("ack_asserted", ack_n, 0);
        n = 0;
        while (!ack_n && n < 40) begin @(posedge clk); #1 n++; end
        chk("ack_released", ack_n, 1);
    endtask

    task automatic poll(input logic [39:0] cm, input int abort_b, input int cancel_b, input bit chg, input logic [15:0] nb);
        logic [15:0] snap;
        logic [7:0]  r, c;
        bit          ok = 1'b1, full = 1'b0, aborted = 1'b0;
        int          a0, p0, acks_exp = 0;
        chk_en = 1'b0;
        a0 = acks;
        p0 = pdone;
        snap = buttons;
        @(posedge clk); #1 sel_n = 1'b0;
        repeat (6) @(posedge clk);
        for (int b = 0; b < 5; b++) begin
            c = cm[b*8 +: 8];
            if (b == 2 && chg) buttons = nb;
            if (b == abort_b) begin
                tail = 7;
                send_byte(c, 4, r);
                aborted = 1'b1;
                break;
            end
            tail = (ok && b < 4 && b == cancel_b) ? 4 : 7;
            send_byte(c, 8, r);
            got[b] = r;
            chk($sformatf("byte%0d_dat", b), r, ok ? resp(b, snap) : 8'hFF);
            if ((b == 0 && c != 8'h01) || (b == 1 && c != 8'h42)) ok = 1'b0;
            if (b == 0) chk("busy_after_byte0", busy, ok);
            if (ok && b == 3) ms_m = c[0];
            if (ok && b == 4) begin ml_m = c; full = 1'b1; end
            if (ok && b < 4 && b != cancel_b) begin acks_exp++; wait_ack(); end
        end
        tail = 7;
        @(posedge clk); #1
        chk("busy_before_release", busy, ok);
        if (!aborted) chk("dat_released_at_end", dat, 1);
        sel_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("release_dat", dat, 1);
        chk("release_busy", busy, 0);
        chk("release_ack_n", ack_n, 1);
        chk("ack_count", acks - a0, acks_exp);
        chk("poll_done_count", pdone - p0, full);
        chk_en = 1'b1;
    endtask

    initial begin
        int a;
        logic [7:0] c0, c1, c2, c3, c4;
        repeat (3) @(posedge clk);
        #1 chk("rst_dat", dat, 1);
        chk("rst_ack_n", ack_n, 1);
        chk("rst_motor_small", motor_small, 0);
        chk("rst_motor_large", motor_large, 0);
        chk("rst_busy", busy, 0);
        chk("rst_poll_done", poll_done, 0);
        n_reset = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("sel_low_at_reset_busy", busy, 0);
        chk("sel_low_at_reset_dat", dat, 1);
        sel_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk_en = 1'b1;

        buttons = 16'hFFFE;
        a = acks;
        poll(40'h00_00_00_42_01, -1, -1, 1'b0, 16'h0);
        chk("poll1_bytes", {got[4], got[3], got[2], got[1], got[0]}, 40'hFF_FE_5A_41_FF);
        chk("poll1_acks", acks - a, 4);

        buttons = 16'h1357;
        poll(40'hA5_01_00_42_01, -1, -1, 1'b0, 16'h0);
        chk("motor_small_set", motor_small, 1);
        chk("motor_large_set", motor_large, 8'hA5);
        poll(40'h00_00_00_42_01, -1, -1, 1'b0, 16'h0);
        chk("motor_small_clear", motor_small, 0);
        chk("motor_large_clear", motor_large, 8'h00);

        poll(40'hA5_01_00_42_01, -1, -1, 1'b0, 16'h0);
        a = acks;
        poll(40'h00_00_00_42_81, -1, -1, 1'b0, 16'h0);
        chk("ignore_no_ack", acks - a, 0);
        chk("ignore_motor_large", motor_large, 8'hA5);

        poll(40'h00_00_00_42_01, 3, -1, 1'b0, 16'h0);
        chk("abort_motor_small", motor_small, 1);
        chk("abort_motor_large", motor_large, 8'hA5);
        buttons = 16'h2468;
        poll(40'h3C_01_00_42_01, -1, -1, 1'b0, 16'h0);
        chk("after_abort_bytes", {got[4], got[3]}, 16'h2468);

        buttons = 16'hFFFF;
        poll(40'h00_00_00_42_01, -1, -1, 1'b1, 16'h0000);
        chk("snapshot_bytes", {got[4], got[3]}, 16'hFFFF);
        poll(40'h00_00_00_42_01, -1, -1, 1'b0, 16'h0);
        chk("next_poll_bytes", {got[4], got[3]}, 16'h0000);

        buttons = 16'h1234;
        a = acks;
        poll(40'h00_00_00_42_01, -1, 1, 1'b0, 16'h0);
        chk("cancel_acks", acks - a, 3);
        chk("cancel_bytes", {got[4], got[3], got[2]}, 24'h12_34_5A);

        for (int k = 0; k < 25; k++) begin
            buttons = 16'($urandom);
            c0 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
            c1 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h42;
            c2 = 8'($urandom);
            c3 = 8'($urandom);
            c4 = 8'($urandom);
            poll({c4, c3, c2, c1, c0}, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1,
                 int'($urandom_range(0, 5)), 1'b0, 16'h0);
        end
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
